// File: rtl/b11_host.sv
// ---------------------------------------------------------------------------
// b11_host
//
// Host-side sequencer for an external 6-bit scrambler. Upstream words are
// buffered in a 4-entry FIFO and launched one at a time: the scrambler sees
// a single-cycle low pulse on stbi together with the word on x_in. After GAP
// guard cycles the scrambler result on x_out is sampled and offered
// downstream with a valid/ready handshake, together with the launched word
// and a prediction of whether the scrambler rejected it.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream word offered
//   in_ready   FIFO can accept (occupancy < 4)
//   in_data    word to scramble
//   stbi       strobe to scrambler, low for one cycle per launched word
//   x_in       word presented to scrambler
//   x_out      scrambler result
//   res_valid  result available
//   res_ready  downstream accepts result
//   res_word   word that produced this result
//   res_data   sampled x_out
//   res_rej    word predicted rejected (not 0, not 63, and > 26)
// ---------------------------------------------------------------------------
module b11_host #(
  parameter int GAP = 16  // legal range 12..63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic       stbi,
  output logic [5:0] x_in,
  input  logic [5:0] x_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_word,
  output logic [5:0] res_data,
  output logic       res_rej
);

  typedef enum logic [2:0] {
    WAKE,
    IDLE,
    LAUNCH,
    GUARD,
    CAPTURE
  } state_t;

  localparam logic [5:0] GUARD_LOAD = 6'(GAP - 1);

  // Scrambler rejection rule, unsigned 6-bit compares only.
  function automatic logic is_rejected(input logic [5:0] w);
    return (w != 6'd0) && (w != 6'd63) && (w > 6'd26);
  endfunction

  // -------------------------------------------------------------------------
  // Input FIFO
  // -------------------------------------------------------------------------
  logic [5:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  state_t     state;
  logic       push;
  logic       pop;

  assign in_ready = (count < 3'd4);
  assign push     = in_valid && in_ready;
  // IDLE only moves to LAUNCH with a non-empty FIFO, so a pop never underflows.
  assign pop      = (state == LAUNCH);

  // NOTE: the storage array has no reset; count/pointers decide which entries
  // are live, so stale contents after reset are never observed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Launch / capture sequencer
  //
  // x_in doubles as the held word: it is loaded with the FIFO head on the way
  // into LAUNCH (the same entry that LAUNCH pops) and stays put through GUARD,
  // CAPTURE and the following IDLE.
  // -------------------------------------------------------------------------
  logic       wake_cnt;
  logic [5:0] guard_cnt;

  // NOTE: every register here is state, so each assignment is non-blocking;
  // a blocking assignment would let later lines see this cycle's new value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= WAKE;
      stbi      <= 1'b1;
      x_in      <= 6'd0;
      wake_cnt  <= 1'b0;
      guard_cnt <= 6'd0;
      res_valid <= 1'b0;
      res_word  <= 6'd0;
      res_data  <= 6'd0;
      res_rej   <= 1'b0;
    end else begin
      unique case (state)
        // The scrambler needs two cycles after reset to reach its wait state.
        WAKE: begin
          stbi <= 1'b1;
          x_in <= 6'd0;
          if (wake_cnt) begin
            wake_cnt <= 1'b0;
            state    <= IDLE;
          end else begin
            wake_cnt <= 1'b1;
          end
        end

        IDLE: begin
          if (count != 3'd0) begin
            stbi  <= 1'b0;
            x_in  <= mem[rd_ptr];
            state <= LAUNCH;
          end
        end

        // Exactly one low cycle: stbi returns high on leaving LAUNCH.
        LAUNCH: begin
          stbi      <= 1'b1;
          guard_cnt <= GUARD_LOAD;
          state     <= GUARD;
        end

        // Counter runs GAP-1 .. 0, so the sampling edge lands GAP+1 cycles
        // after the start of the stbi-low cycle.
        GUARD: begin
          if (guard_cnt == 6'd0) begin
            res_data  <= x_out;
            res_word  <= x_in;
            res_rej   <= is_rejected(x_in);
            res_valid <= 1'b1;
            state     <= CAPTURE;
          end else begin
            guard_cnt <= guard_cnt - 6'd1;
          end
        end

        // res_* hold still until downstream takes the result.
        CAPTURE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= WAKE;
      endcase
    end
  end

endmodule

// File: tb/tb_b11_host.sv
// ---------------------------------------------------------------------------
// tb_b11_host
//
// Directed bench for b11_host. A small scrambler model answers each launch:
// accepted words produce their bit-reversed value on x_out a few cycles
// later, rejected words leave x_out unchanged. A monitor logs every stbi-low
// cycle and every new result; the stimulus checks these logs against
// hand-computed tables.
// ---------------------------------------------------------------------------
module tb_b11_host;

  localparam int GAP = 16;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       stbi;
  logic [5:0] x_in;
  logic [5:0] x_out;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_word;
  logic [5:0] res_data;
  logic       res_rej;

  b11_host #(.GAP(GAP)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .stbi      (stbi),
    .x_in      (x_in),
    .x_out     (x_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_word  (res_word),
    .res_data  (res_data),
    .res_rej   (res_rej)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scrambler model
  // ---------------------------------------------------------------------------
  function automatic logic [5:0] bit_rev(input logic [5:0] w);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = w[5-i];
    return r;
  endfunction

  logic       scr_busy;
  logic [1:0] scr_dly;
  logic [5:0] scr_word;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      scr_busy <= 1'b0;
      scr_dly  <= 2'd0;
      scr_word <= 6'd0;
      x_out    <= 6'd0;
    end else if (!stbi) begin
      scr_busy <= 1'b1;
      scr_dly  <= 2'd3;
      scr_word <= x_in;
    end else if (scr_busy) begin
      if (scr_dly == 2'd0) begin
        scr_busy <= 1'b0;
        if (scr_word == 6'd0 || scr_word == 6'd63 || scr_word <= 6'd26)
          x_out <= bit_rev(scr_word);
      end else begin
        scr_dly <= scr_dly - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [5:0] w;
    logic [5:0] d;
    logic       r;
    int         lat;
  } res_t;

  int         cyc = 0;
  int         lq[$];    // cycle of each stbi-low
  logic [5:0] lw[$];    // x_in during each stbi-low
  res_t       rq[$];    // each new result as it appears
  int         consec = 0;
  logic       prev_low = 1'b0;
  logic       prev_rv  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!stbi) begin
      if (prev_low) consec <= consec + 1;
      lq.push_back(cyc);
      lw.push_back(x_in);
    end
    prev_low <= !stbi;
    if (res_valid && !prev_rv)
      rq.push_back('{w: res_word, d: res_data, r: res_rej,
                     lat: (lq.size() > 0) ? cyc - lq[$] : -1});
    prev_rv <= res_valid;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1ns after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [5:0] w);
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    check("push_tmo", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_rq(input int n);
    int t = 0;
    while (rq.size() < n && t < 400) begin
      tick();
      t++;
    end
    check("res_tmo", 32'(rq.size() >= n), 32'd1);
  endtask

  // Expected result sequence, in order of appearance.
  int exp_w [12] = '{0, 63, 40, 26, 27,  1,  2,  3, 4,  5,  6, 11};
  int exp_d [12] = '{0, 63, 63, 22, 22, 32, 16, 48, 8, 40, 24, 52};
  int exp_r [12] = '{0,  0,  1,  0,  1,  0,  0,  0, 0,  0,  0,  0};

  int rel;
  int nl0;
  int nl1;
  int t;
  logic [5:0] stall_w [4] = '{6'd2, 6'd3, 6'd4, 6'd5};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    res_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_stbi",     32'(stbi),     32'd1);
    check("rst_x_in",     32'(x_in),     32'd0);
    check("rst_rv",       32'(res_valid), 32'd0);
    check("rst_word",     32'(res_word), 32'd0);
    check("rst_data",     32'(res_data), 32'd0);
    check("rst_rej",      32'(res_rej),  32'd0);

    // Word 0 straight after reset release
    reset     = 1'b0;
    rel       = cyc;
    res_ready = 1'b1;
    push(6'd0);
    wait_rq(1);
    check("launch0_cnt", 32'(lq.size()), 32'd1);
    if (lq.size() > 0) begin
      check("wake_delay", 32'((lq[0] - rel) >= 3), 32'd1);
      check("launch0_x",  32'(lw[0]), 32'd0);
    end
    tick();
    check("rv_drop", 32'(res_valid), 32'd0);

    // 63 accepted, then 40 rejected (x_out retained)
    push(6'd63);
    wait_rq(2);
    push(6'd40);
    wait_rq(3);

    // 26 / 27 boundary and launch spacing with res_ready high
    push(6'd26);
    push(6'd27);
    wait_rq(5);
    if (lq.size() >= 5) begin
      check("gap_spacing", 32'(lq[4] - lq[3]), 32'(GAP + 3));
      check("launch27_x",  32'(lw[4]), 32'd27);
    end
    repeat (3) tick();

    // Stalled CAPTURE fills the FIFO
    res_ready = 1'b0;
    push(6'd1);
    wait_rq(6);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = stall_w[i];
      tick();
    end
    check("full_ready", 32'(in_ready), 32'd0);
    in_data = 6'd6;
    nl0 = lq.size();
    repeat (6) tick();
    check("stall_lows",  32'(lq.size() - nl0), 32'd0);
    check("stall_ready", 32'(in_ready),  32'd0);
    check("stall_rv",    32'(res_valid), 32'd1);
    check("stall_word",  32'(res_word),  32'd1);
    check("stall_data",  32'(res_data),  32'd32);
    res_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    check("fifth_tmo", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_rq(11);
    repeat (3) tick();

    // Reset in the middle of GUARD with three words queued
    nl0 = lq.size();
    push(6'd7);
    push(6'd8);
    push(6'd9);
    push(6'd10);
    repeat (3) tick();
    check("guard_launched", 32'(lq.size() - nl0), 32'd1);
    check("guard_rv",       32'(res_valid), 32'd0);
    check("guard_x_in",     32'(x_in), 32'd7);
    reset = 1'b1;
    #1;
    check("arst_stbi",     32'(stbi),      32'd1);
    check("arst_rv",       32'(res_valid), 32'd0);
    check("arst_x_in",     32'(x_in),      32'd0);
    check("arst_in_ready", 32'(in_ready),  32'd1);
    check("arst_word",     32'(res_word),  32'd0);
    tick();
    tick();
    reset = 1'b0;
    rel   = cyc;
    nl1   = lq.size();
    push(6'd11);
    wait_rq(12);
    if (lq.size() > nl1) begin
      check("wake_delay2", 32'((lq[nl1] - rel) >= 3), 32'd1);
      check("launch11_x",  32'(lw[nl1]), 32'd11);
    end
    repeat (40) tick();
    check("no_stale_res",  32'(rq.size()), 32'd12);
    check("no_stale_lows", 32'(lq.size() - nl1), 32'd1);

    // Result log against the expected table
    check("n_results", 32'(rq.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < rq.size()) begin
        check($sformatf("res%0d_word", i), 32'(rq[i].w), 32'(exp_w[i]));
        check($sformatf("res%0d_data", i), 32'(rq[i].d), 32'(exp_d[i]));
        check($sformatf("res%0d_rej",  i), 32'(rq[i].r), 32'(exp_r[i]));
        check($sformatf("res%0d_lat",  i), 32'(rq[i].lat), 32'(GAP + 1));
      end
    end
    check("consec_low", 32'(consec), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/b11_host.md
B11_HOST -- requirements
Module: b11_host

Interface
REQ-001 Parameter GAP, default 16: cycles stbi is held high after each launch before x_out is sampled; legal range 12..63.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream word offered.
REQ-005 in_ready  output  1  FIFO can accept; high when occupancy < 4.
REQ-006 in_data  input  6  word to scramble.
REQ-007 stbi  output  1  strobe to scrambler; low for exactly one cycle per launched word.
REQ-008 x_in  output  6  word presented to scrambler.
REQ-009 x_out  input  6  scrambler result.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  downstream accepts result.
REQ-012 res_word  output  6  word that produced this result.
REQ-013 res_data  output  6  sampled x_out.
REQ-014 res_rej  output  1  word predicted rejected: not 0, not 63, and > 26.

Function
REQ-015 Input FIFO: 4 entries x 6 bits, wrap-around read/write pointers, 3-bit occupancy count.
REQ-016 Push when in_valid && in_ready; pop only in LAUNCH.
REQ-017 Simultaneous push and pop leave occupancy unchanged; push to full is blocked by in_ready=0; pop from empty never occurs.
REQ-018 FSM states: WAKE, IDLE, LAUNCH, GUARD, CAPTURE.
REQ-019 WAKE: stbi=1, x_in=0; 2-cycle counter; then to IDLE (scrambler needs two cycles after reset to reach its wait state).
REQ-020 IDLE: stbi=1, x_in=last launched word (0 after reset); to LAUNCH when FIFO non-empty.
REQ-021 LAUNCH (one cycle): stbi=0, x_in=FIFO head; pop head into held word; load guard counter with GAP-1; to GUARD.
REQ-022 GUARD: stbi=1, x_in=held word; decrement counter; to CAPTURE on the cycle counter is 0.
REQ-023 CAPTURE: sample x_out into res_data once on entry; res_word=held word; res_rej computed from held word; res_valid=1.
REQ-024 CAPTURE exit: stay while res_ready=0, with res_* stable; on res_valid && res_ready, next state IDLE and res_valid=0 next cycle.
REQ-025 Launch-to-sample latency is exactly GAP+1 cycles, measured from the stbi-low cycle to the x_out sampling edge.
REQ-026 Minimum spacing between stbi-low cycles is GAP+3 cycles.
REQ-027 stbi is never low outside LAUNCH; no two consecutive low cycles.
REQ-028 Rejected words are still launched; res_data then holds the scrambler's previous x_out, unchanged.
REQ-029 res_rej: 6-bit unsigned comparisons only.
REQ-030 FIFO accepts pushes in every state, including WAKE and CAPTURE stall.

Reset
REQ-031 On reset assertion (any state, mid-GUARD included), asynchronously:
- FIFO emptied, pointers 0, in_ready=1;
- state=WAKE, stbi=1, x_in=0;
- res_valid=0, res_data=0, res_word=0, res_rej=0;
- guard counter 0, wake counter 0.
REQ-032 After reset deasserts, the first stbi-low cycle occurs no earlier than the 3rd rising edge.
REQ-033 Words in flight or queued at reset are discarded without a result.

Verification
REQ-034 Reset release, push 0, res_ready=1 -> one stbi-low cycle with x_in=0; GAP+1 cycles later res_valid=1, res_word=0, res_data=0, res_rej=0.
REQ-035 Push 63 -> res_word=63, res_data=63, res_rej=0.
REQ-036 Push 40 after 63 -> res_rej=1, res_data=63 (previous x_out retained).
REQ-037 Push 5 words back-to-back, res_ready=0 -> in_ready=0 after 4 accepted; fifth held until pop; stbi stays high while CAPTURE stalls; results return in order once res_ready=1.
REQ-038 Assert reset during GUARD with 3 words queued -> stbi=1 and res_valid=0 immediately; no result for queued words; next launch only after the WAKE delay.
REQ-039 Push 26 and 27 -> 26: res_rej=0; 27: res_rej=1; spacing between stbi-low cycles checked equal to GAP+3 with res_ready tied high.
